// File: rtl/fifo_pkg.sv
// Shared types and constants for the fifo block and its verification element type.
package fifo_pkg;

   localparam int FIFO_DEPTH_DEF = 8;

   typedef struct packed {
      int cpf;
      int idade;
      int rg;
   } person_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Read/write pointers, occupancy counter and push/pop acceptance for the fifo.
module fifo_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int BUFF_SIZE = FIFO_DEPTH_DEF,
   parameter int PW        = $clog2(BUFF_SIZE),
   parameter int CW        = $clog2(BUFF_SIZE + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   output logic          push_ok,
   output logic          pop_ok,
   output logic [PW-1:0] rd_ptr,
   output logic [PW-1:0] wr_ptr,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   assign full  = (count_q == CW'(BUFF_SIZE));
   assign empty = (count_q == '0);

   // A pop at full frees the slot the same edge, so the push rides along.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (pop_ok)
         rd_ptr_d = (rd_ptr_q == PW'(BUFF_SIZE - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (push_ok)
         wr_ptr_d = (wr_ptr_q == PW'(BUFF_SIZE - 1)) ? '0 : wr_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rd_ptr = rd_ptr_q;
   assign wr_ptr = wr_ptr_q;
   assign count  = count_q;

endmodule

// File: rtl/fifo.sv
// Single-clock FIFO generic over element type; registered data_out, no fall-through.
module fifo
   import fifo_pkg::*;
#(
   parameter int  BUFF_SIZE = FIFO_DEPTH_DEF,
   parameter type dtype     = logic [7:0]
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  dtype                         data_in,
   output dtype                         data_out,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(BUFF_SIZE+1)-1:0] count
);

   localparam int PW = $clog2(BUFF_SIZE);
   localparam int CW = $clog2(BUFF_SIZE + 1);

   logic          push_ok, pop_ok;
   logic [PW-1:0] rd_ptr, wr_ptr;
   dtype          mem [BUFF_SIZE];
   dtype          data_out_q;

   fifo_ptr_ctrl #(
      .BUFF_SIZE (BUFF_SIZE),
      .PW        (PW),
      .CW        (CW)
   ) u_ptr_ctrl (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .push_ok (push_ok),
      .pop_ok  (pop_ok),
      .rd_ptr  (rd_ptr),
      .wr_ptr  (wr_ptr),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   // Storage is never reset; pop_ok guarantees only written slots are read.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         data_out_q <= '0;
      else if (pop_ok)
         data_out_q <= mem[rd_ptr];
   end

   assign data_out = data_out_q;

endmodule

// File: tb/tb_fifo.sv
// Scoreboard-driven bench for fifo with person_t elements at the default depth.
module tb_fifo;
   import fifo_pkg::*;

   logic       clk = 1'b0, rst = 1'b0, push = 1'b0, pop = 1'b0;
   person_t    data_in = '0;
   person_t    data_out;
   logic       full, empty;
   logic [3:0] count;

   int         tests = 0, fails = 0;
   person_t    sb[$];
   person_t    exp_out = '0;
   int         mcount = 0;

   always #5 clk = ~clk;

   fifo #(.BUFF_SIZE(FIFO_DEPTH_DEF), .dtype(person_t)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .data_in(data_in),
      .data_out(data_out), .full(full), .empty(empty), .count(count)
   );

   function automatic person_t mk(input int n);
      person_t p;
      p.cpf = n; p.idade = n + 19; p.rg = n;
      return p;
   endfunction

   task automatic model_reset();
      sb.delete(); mcount = 0; exp_out = '0;
   endtask

   // One clock with the given request; the reference model predicts acceptance.
   task automatic step(input logic pu, input logic po, input person_t d);
      bit pa, oa;
      push = pu; pop = po; data_in = d;
      oa = po && (mcount > 0);
      pa = pu && ((mcount < FIFO_DEPTH_DEF) || oa);
      @(posedge clk); #1;
      if (oa) exp_out = sb.pop_front();
      if (pa) sb.push_back(d);
      mcount = mcount + int'(pa) - int'(oa);
      push = 1'b0; pop = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; @(posedge clk); #1; rst = 1'b1; model_reset();
      tests++;
      if (data_out !== person_t'('0)) begin fails++; $display("FAIL reset_data got %h exp 0", data_out); end
      tests++;
      if ({full, empty, count} !== {1'b0, 1'b1, 4'd0}) begin
         fails++; $display("FAIL reset_status got f%b e%b c%0d exp f0 e1 c0", full, empty, count);
      end
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 7; i++) step(1'b1, 1'b0, mk(i));
      tests++;
      if ({full, empty, count} !== {1'b0, 1'b0, 4'd7}) begin
         fails++; $display("FAIL fill7_status got f%b e%b c%0d exp f0 e0 c7", full, empty, count);
      end
      tests++;
      if (data_out !== person_t'('0)) begin fails++; $display("FAIL fill7_data got %h exp 0", data_out); end
   endtask

   task automatic test_pop_refill();
      step(1'b0, 1'b1, '0);
      tests++;
      if (data_out !== mk(1) || data_out !== exp_out) begin
         fails++; $display("FAIL pop1_data got %h exp %h", data_out, mk(1));
      end
      tests++;
      if (count !== 4'd6) begin fails++; $display("FAIL pop1_count got %0d exp 6", count); end
      step(1'b1, 1'b0, mk(8));
      step(1'b1, 1'b0, mk(9));
      tests++;
      if ({full, empty, count} !== {1'b1, 1'b0, 4'd8}) begin
         fails++; $display("FAIL refill_status got f%b e%b c%0d exp f1 e0 c8", full, empty, count);
      end
   endtask

   task automatic test_drain();
      for (int i = 2; i <= 9; i++) begin
         step(1'b0, 1'b1, '0);
         tests++;
         if (data_out !== mk(i) || data_out !== exp_out) begin
            fails++; $display("FAIL drain_%0d got %h exp %h", i, data_out, mk(i));
         end
      end
      tests++;
      if ({full, empty, count} !== {1'b0, 1'b1, 4'd0}) begin
         fails++; $display("FAIL drain_status got f%b e%b c%0d exp f0 e1 c0", full, empty, count);
      end
   endtask

   task automatic test_overflow_underflow();
      person_t bad;
      bad.cpf = 99; bad.idade = 99; bad.rg = 99;
      for (int i = 10; i <= 17; i++) step(1'b1, 1'b0, mk(i));
      step(1'b1, 1'b0, bad);
      tests++;
      if ({full, count} !== {1'b1, 4'd8}) begin
         fails++; $display("FAIL overflow_status got f%b c%0d exp f1 c8", full, count);
      end
      for (int i = 10; i <= 17; i++) begin
         step(1'b0, 1'b1, '0);
         tests++;
         if (data_out !== exp_out || data_out.cpf == 99) begin
            fails++; $display("FAIL overflow_pop_%0d got %h exp %h", i, data_out, exp_out);
         end
      end
      step(1'b0, 1'b1, '0);
      tests++;
      if (data_out !== mk(17) || count !== 4'd0 || empty !== 1'b1) begin
         fails++; $display("FAIL underflow_hold got %h c%0d exp %h c0", data_out, count, mk(17));
      end
   endtask

   task automatic test_simul();
      step(1'b1, 1'b1, mk(20));
      tests++;
      if (count !== 4'd1 || data_out !== mk(17)) begin
         fails++; $display("FAIL simul_empty got c%0d %h exp c1 %h", count, data_out, mk(17));
      end
      for (int i = 21; i <= 23; i++) step(1'b1, 1'b0, mk(i));
      step(1'b1, 1'b1, mk(24));
      tests++;
      if (count !== 4'd4 || data_out !== mk(20) || data_out !== exp_out) begin
         fails++; $display("FAIL simul_mid got c%0d %h exp c4 %h", count, data_out, mk(20));
      end
      for (int i = 25; i <= 28; i++) step(1'b1, 1'b0, mk(i));
      step(1'b1, 1'b1, mk(29));
      tests++;
      if ({full, count} !== {1'b1, 4'd8} || data_out !== mk(21) || data_out !== exp_out) begin
         fails++; $display("FAIL simul_full got f%b c%0d %h exp f1 c8 %h", full, count, data_out, mk(21));
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, '0);
         tests++;
         if (data_out !== exp_out) begin
            fails++; $display("FAIL simul_pop_%0d got %h exp %h", i, data_out, exp_out);
         end
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk); #2;
      rst = 1'b0; #1;
      tests++;
      if ({full, empty, count} !== {1'b0, 1'b1, 4'd0} || data_out !== person_t'('0)) begin
         fails++; $display("FAIL async_reset got f%b e%b c%0d %h exp f0 e1 c0 0", full, empty, count, data_out);
      end
      @(negedge clk); rst = 1'b1; model_reset();
      step(1'b1, 1'b0, mk(40));
      step(1'b0, 1'b1, '0);
      tests++;
      if (data_out !== mk(40) || data_out !== exp_out || count !== 4'd0) begin
         fails++; $display("FAIL post_reset got %h c%0d exp %h c0", data_out, count, mk(40));
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_pop_refill();
      test_drain();
      test_overflow_underflow();
      test_simul();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo.md
Name: fifo

Overview:
- Synchronous single-clock first-in-first-out buffer, generic over element type via a type parameter.
- Stores up to BUFF_SIZE entries written by push and returns them in order on a registered data_out when popped.
- Used as a general queueing block between producer and consumer logic. Status outputs expose full, empty and occupancy.

Parameters:
- BUFF_SIZE, 8, number of storage entries; any integer >= 2, need not be a power of two.
- dtype, logic [7:0], element type (type parameter); any packed type, e.g. a 96-bit struct of three int fields.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- push  input  1  write request; data_in is enqueued on the clock edge if not full.
- pop  input  1  read request; head entry is dequeued to data_out on the clock edge if not empty.
- data_in  input  $bits(dtype)  element to enqueue.
- data_out  output  $bits(dtype)  last dequeued element (registered).
- full  output  1  high when count == BUFF_SIZE.
- empty  output  1  high when count == 0.
- count  output  $clog2(BUFF_SIZE+1)  current occupancy.

Behaviour:
- Reset (rst low, asynchronous, any time including mid-operation):
  - read pointer, write pointer and count go to 0;
  - data_out goes to all-zero; full goes to 0; empty goes to 1;
  - storage contents need not be cleared.
- Push accepted when push=1 and not full:
  - mem[wr_ptr] <= data_in;
  - wr_ptr advances; wraps from BUFF_SIZE-1 to 0.
- Pop accepted when pop=1 and not empty:
  - data_out <= mem[rd_ptr];
  - rd_ptr advances with the same wrap rule;
  - the element is visible on data_out after the same rising edge (1-cycle latency from pop sample).
- data_out holds its value on cycles with no accepted pop.
- Push while full (and no pop): ignored; data discarded, no state change.
- Pop while empty: ignored; data_out holds, pointers and count unchanged.
- Simultaneous push and pop:
  - not empty and not full: both accepted, count unchanged;
  - full: both accepted (pop frees the slot in the same edge), count stays BUFF_SIZE;
  - empty: only the push is accepted, data_out unchanged (no fall-through).
- count: +1 on push-only accepted, -1 on pop-only accepted, unchanged otherwise.
- full and empty are derived combinationally from count, or registered consistently with it; they must never disagree with count.
- No X propagation from unwritten entries: a pop can only read written slots.

Decomposition:
- Shared package fifo_pkg holds:
  - person_t packed struct {int cpf; int idade; int rg} used as the verification element type;
  - default-depth constant FIFO_DEPTH_DEF = 8.
- fifo keeps the storage array inline.
- One natural sub-module, fifo_ptr_ctrl, holds pointer, wrap and count logic, parameterised by BUFF_SIZE and outputting rd_ptr, wr_ptr, count, full and empty.

Test Plan:
- Reset with rst=0 for one cycle, then release -> data_out=0, empty=1, full=0, count=0.
- Push person_t {1,20,1} through {7,26,7} on 7 consecutive cycles -> count=7, full=0, empty=0, data_out still 0.
- One pop -> data_out={1,20,1}, count=6; then push {8,27,8} and {9,28,9} -> count=8, full=1.
- Eight consecutive pops -> data_out sequence {2,21,2},{3,22,3},...,{9,28,9}; then empty=1, count=0; pointers have wrapped.
- Push while full with {99,99,99} -> ignored, count stays 8, later pops never return 99. Pop while empty -> data_out holds last value.
- Simultaneous push+pop at full, at mid-level and at empty -> counts 8/unchanged/1 as specified. Assert rst mid-stream -> immediate empty=1, data_out=0 without waiting for a clock edge.
